acc_norm_pipe: RTL

- Parametrised, pipelined normaliser for the wide two's-complement quire/accumulator.
- Converts the accumulator to sign, signed scale factor, 1.f mantissa and ovf/udf/nzero flags.
- Generalises segment count, segment width, binary-point position and mantissa width.
- Adds valid/ready backpressure, a per-transaction tag and synchronous flush; sits between the MAC accumulator and the posit/float encoder.

---
 rtl/acc_norm_pkg.sv | 61 ++++++
 rtl/acc_norm_if.sv | 30 +++
 rtl/acc_norm_lzd.sv | 19 +
 rtl/acc_norm_pipe.sv | 125 ++++++++++++
 4 files changed

// File: rtl/acc_norm_pkg.sv
// Shared widths, stage payload and result types for the accumulator normaliser.
// The optional round-to-nearest-even path is ACC_NORM_RNE_EN (see acc_norm_pipe).
package acc_norm_pkg;

   localparam int SEGW   = 24;
   localparam int SEGS   = 4;
   localparam int HEAD   = 6;
   localparam int FRAC   = 48;
   localparam int MTSW   = 8;
   localparam int SF_MAX = 23;
   localparam int SF_MIN = -24;
   localparam int TAGW   = 4;
   localparam int ACCW   = HEAD + SEGS * SEGW;
   localparam int SFW    = $clog2(ACCW) + 2;
   localparam int PW     = $clog2(ACCW);

   localparam logic signed [SFW-1:0] SF_MAX_S = SFW'(SF_MAX);
   localparam logic signed [SFW-1:0] SF_MIN_S = SFW'(SF_MIN);

   typedef struct packed {
      logic            sign;
      logic [ACCW-1:0] mag;
      logic [TAGW-1:0] tag;
   } payload_t;

   typedef struct packed {
      logic [SFW-1:0]  sf;
      logic [MTSW-1:0] mts;
      logic            ovf;
      logic            udf;
      logic            nzero;
   } result_t;

   // Clamp the scale factor to the encoder's range and encode the flags.
   function automatic result_t sf_sat(input logic zero,
                                      input logic signed [SFW-1:0] sf,
                                      input logic [MTSW-1:0] mts);
      result_t r;
      r.sf    = sf;
      r.mts   = mts;
      r.ovf   = 1'b0;
      r.udf   = 1'b0;
      r.nzero = 1'b1;
      if (zero) begin
         r.sf    = '0;
         r.mts   = '0;
         r.udf   = 1'b1;
         r.nzero = 1'b0;
      end else if (sf > SF_MAX_S) begin
         r.ovf = 1'b1;
         r.sf  = SF_MAX_S;
         r.mts = '1;
      end else if (sf < SF_MIN_S) begin
         r.udf = 1'b1;
         r.sf  = SF_MIN_S;
         r.mts = '0;
      end
      return r;
   endfunction

endpackage

// File: rtl/acc_norm_if.sv
// Stream interface between the MAC accumulator, the normaliser and the encoder.
interface acc_norm_if;
   import acc_norm_pkg::*;

   logic            clr_i;
   logic            in_vld_i;
   logic            in_rdy_o;
   logic [ACCW-1:0] acc_i;
   logic [TAGW-1:0] tag_i;
   logic            out_vld_o;
   logic            out_rdy_i;
   logic [TAGW-1:0] tag_o;
   logic            sign_o;
   logic [SFW-1:0]  sf_o;
   logic [MTSW-1:0] mts_o;
   logic            ovf_o;
   logic            udf_o;
   logic            nzero_o;

   modport slave (
      input  clr_i, in_vld_i, acc_i, tag_i, out_rdy_i,
      output in_rdy_o, out_vld_o, tag_o, sign_o, sf_o, mts_o, ovf_o, udf_o, nzero_o
   );

   modport master (
      output clr_i, in_vld_i, acc_i, tag_i, out_rdy_i,
      input  in_rdy_o, out_vld_o, tag_o, sign_o, sf_o, mts_o, ovf_o, udf_o, nzero_o
   );

endinterface

// File: rtl/acc_norm_lzd.sv
// Combinational leading-one detector: position of the highest set bit and a zero flag.
module acc_norm_lzd #(
   parameter int W  = 102,
   parameter int PW = $clog2(W)
) (
   input  logic [W-1:0]  vec,
   output logic [PW-1:0] pos,
   output logic          zero
);

   always_comb begin
      pos  = '0;
      zero = ~|vec;
      for (int i = 0; i < W; i++) begin
         if (vec[i]) pos = PW'(i);
      end
   end

endmodule

// File: rtl/acc_norm_pipe.sv
// Three-stage accumulator normaliser: sign/magnitude, leading-one position, align+saturate.
// Define ACC_NORM_RNE_EN for round-to-nearest-even instead of truncation.
module acc_norm_pipe
   import acc_norm_pkg::*;
(
   input  logic        clk_i,
   input  logic        rstn,
   acc_norm_if.slave   bus
);

   logic            v1, v2, v3;
   logic            rdy1, rdy2, rdy3;
   logic            accept;
   payload_t        s1, s2;
   logic [PW-1:0]   lzd_pos, s2_pos;
   logic            lzd_zero, s2_zero;

   logic [PW-1:0]   sh;
   logic [ACCW-1:0] aligned;
   logic [MTSW-1:0] mts_t, mts_r;
   logic [SFW-1:0]  sf_raw, sf_r;
   result_t         res, s3_res;
   logic            s3_sign;
   logic [TAGW-1:0] s3_tag;

   // Bubble-collapsing: a stage may load whenever the one ahead is empty or draining.
   assign rdy3         = ~v3 | bus.out_rdy_i;
   assign rdy2         = ~v2 | rdy3;
   assign rdy1         = ~v1 | rdy2;
   assign bus.in_rdy_o = rdy1 & ~bus.clr_i;
   assign accept       = bus.in_vld_i & bus.in_rdy_o;

   always_ff @(posedge clk_i or negedge rstn) begin
      if (!rstn) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         v3 <= 1'b0;
      end else if (bus.clr_i) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         v3 <= 1'b0;
      end else begin
         if (rdy1) v1 <= bus.in_vld_i;
         if (rdy2) v2 <= v1;
         if (rdy3) v3 <= v2;
      end
   end

   // Negating the most negative value yields 1<<(ACCW-1), which read unsigned is exact.
   always_ff @(posedge clk_i or negedge rstn) begin
      if (!rstn) begin
         s1 <= '0;
      end else if (accept) begin
         s1.sign <= bus.acc_i[ACCW-1];
         s1.mag  <= bus.acc_i[ACCW-1] ? (~bus.acc_i + ACCW'(1)) : bus.acc_i;
         s1.tag  <= bus.tag_i;
      end
   end

   acc_norm_lzd #(.W(ACCW), .PW(PW)) u_lzd (
      .vec  (s1.mag),
      .pos  (lzd_pos),
      .zero (lzd_zero)
   );

   always_ff @(posedge clk_i or negedge rstn) begin
      if (!rstn) begin
         s2      <= '0;
         s2_pos  <= '0;
         s2_zero <= 1'b1;
      end else if (rdy2 && v1) begin
         s2      <= s1;
         s2_pos  <= lzd_pos;
         s2_zero <= lzd_zero;
      end
   end

   assign sh      = PW'(ACCW-1) - s2_pos;
   assign aligned = s2.mag << sh;
   assign mts_t   = aligned[ACCW-1 -: MTSW];
   assign sf_raw  = {{(SFW-PW){1'b0}}, s2_pos} - SFW'(FRAC);

`ifdef ACC_NORM_RNE_EN
   logic            guard, sticky, rnd, cy;
   logic [MTSW-1:0] mts_sum;

   assign guard  = aligned[ACCW-1-MTSW];
   assign sticky = |aligned[ACCW-2-MTSW:0];
   assign rnd    = guard & (sticky | mts_t[0]);
   assign {cy, mts_sum} = {1'b0, mts_t} + (MTSW+1)'(rnd);
   // Carry-out renormalises to 1.000.. and bumps the exponent before the range check.
   assign mts_r  = cy ? {1'b1, {(MTSW-1){1'b0}}} : mts_sum;
   assign sf_r   = cy ? (sf_raw + SFW'(1)) : sf_raw;
`else
   logic unused_low;

   assign unused_low = ^aligned[ACCW-1-MTSW:0];
   assign mts_r      = mts_t;
   assign sf_r       = sf_raw;
`endif

   assign res = sf_sat(s2_zero, sf_r, mts_r);

   always_ff @(posedge clk_i or negedge rstn) begin
      if (!rstn) begin
         s3_res  <= '{sf: '0, mts: '0, ovf: 1'b0, udf: 1'b0, nzero: 1'b1};
         s3_sign <= 1'b0;
         s3_tag  <= '0;
      end else if (rdy3 && v2) begin
         s3_res  <= res;
         s3_sign <= s2.sign & ~s2_zero;
         s3_tag  <= s2.tag;
      end
   end

   assign bus.out_vld_o = v3;
   assign bus.tag_o     = s3_tag;
   assign bus.sign_o    = s3_sign;
   assign bus.sf_o      = s3_res.sf;
   assign bus.mts_o     = s3_res.mts;
   assign bus.ovf_o     = s3_res.ovf;
   assign bus.udf_o     = s3_res.udf;
   assign bus.nzero_o   = s3_res.nzero;

endmodule
